// File: rtl/sraml_axi_bridge.sv
// SRAM-like inst/data masters to a single AXI3 master port.
// One single-beat transaction in flight; data side wins arbitration.
module sraml_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        inst_ok_q, data_ok_q;
  logic        idle_free, accept;
  logic        aw_fin, w_fin;
  logic [3:0]  strb;
  logic        unused_ok;

  assign unused_ok = ^{inst_wr, inst_wdata, rid, rlast};

  // No accept during a data_ok cycle: next request waits one more cycle.
  assign idle_free = (state_q == S_IDLE) & ~rst
                   & ~inst_ok_q & ~data_ok_q;
  assign data_addr_ok = idle_free & data_req;
  assign inst_addr_ok = idle_free & inst_req & ~data_req;
  assign accept = data_addr_ok | inst_addr_ok;

  assign aw_fin = aw_done_q | (awvalid & awready);
  assign w_fin  = w_done_q | (wvalid & wready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = (data_addr_ok & data_wr) ? S_AW : S_AR;
      S_AR: if (arready) state_d = S_R;
      S_R:  if (rvalid) state_d = S_IDLE;
      S_AW: if (aw_fin & w_fin) state_d = S_B;
      S_B:  if (bvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (data_addr_ok) begin
      owner_d = 1'b1;
      wr_d    = data_wr;
      size_d  = data_size;
      addr_d  = data_addr;
      wdata_d = data_wdata;
    end else if (inst_addr_ok) begin
      owner_d = 1'b0;
      wr_d    = 1'b0;
      size_d  = inst_size;
      addr_d  = inst_addr;
      wdata_d = 32'h0;
    end
  end

  always_comb begin
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (state_q == S_AW && !(aw_fin && w_fin)) begin
      aw_done_d = aw_fin;
      w_done_d  = w_fin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      inst_ok_q <= (state_q == S_R) & rvalid & ~owner_q;
      data_ok_q <= ((state_q == S_R) & rvalid & owner_q)
                 | ((state_q == S_B) & bvalid);
      if (state_q == S_R && rvalid && !owner_q)
        inst_rdata_q <= rdata;
      if (state_q == S_R && rvalid && owner_q)
        data_rdata_q <= rdata;
    end
  end

  always_comb begin
    strb = 4'b1111;
    unique case (size_q)
      2'd0: strb = 4'b0001 << addr_q[1:0];
      2'd1: strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = {3'b000, owner_q};
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);

  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awvalid = (state_q == S_AW) & ~aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = (state_q == S_AW) ? strb : 4'b0000;
  assign wvalid  = (state_q == S_AW) & ~w_done_q;
  assign bready  = (state_q == S_B);

endmodule
